// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with selectable baud, oversampled mid-bit sampling and a
// one-entry valid/ready output holding register with overrun and framing flags.
module uart_rx_ctrl #(
  parameter int CLK_HZ = 50000000,
  parameter int OSR    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] baud_sel,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CLK_HZ_U = CLK_HZ;
  localparam int unsigned OSR_U    = OSR;
  localparam int          SW       = $clog2(OSR);
  localparam logic [SW-1:0] MID    = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] LAST   = SW'(OSR - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic [2:0]    baud_q;
  logic [15:0]   div;
  logic [15:0]   tick_cnt;
  logic [SW-1:0] sample_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tick;
  logic          sample_end;
  logic          byte_done;

  // Clock cycles per oversampling tick for a given baud select, never below 1.
  function automatic logic [15:0] div_for(input logic [2:0] sel);
    int unsigned baud;
    int unsigned q;
    case (sel)
      3'd0:    baud = 32'd9600;
      3'd1:    baud = 32'd19200;
      3'd2:    baud = 32'd38400;
      3'd3:    baud = 32'd57600;
      3'd4:    baud = 32'd115200;
      3'd5:    baud = 32'd230400;
      3'd6:    baud = 32'd460800;
      default: baud = 32'd921600;
    endcase
    q = CLK_HZ_U / (OSR_U * baud);
    if (q == 32'd0) q = 32'd1;
    return q[15:0];
  endfunction

  assign div        = div_for(baud_q);
  assign tick       = (state != IDLE) && (tick_cnt >= div - 16'd1);
  assign sample_end = tick && (sample_cnt == LAST);
  assign byte_done  = (state == STOP) && sample_end && rx_s;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_q     <= 3'd0;
      tick_cnt   <= 16'd0;
      sample_cnt <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      data       <= 8'h00;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (state == IDLE || tick) tick_cnt <= 16'd0;
      else                       tick_cnt <= tick_cnt + 16'd1;

      case (state)
        IDLE: begin
          // Only a fresh high-to-low transition opens a frame.
          if (rx_prev && !rx_s) begin
            baud_q     <= baud_sel;
            tick_cnt   <= 16'd0;
            sample_cnt <= '0;
            state      <= START;
          end
        end
        START: begin
          if (tick) begin
            if (sample_cnt == MID) begin
              sample_cnt <= '0;
              bit_cnt    <= 3'd0;
              state      <= rx_s ? IDLE : DATA;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sample_cnt == LAST) begin
              sample_cnt <= '0;
              shift      <= {rx_s, shift[7:1]};
              bit_cnt    <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= STOP;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sample_cnt == LAST) begin
              sample_cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Holding register: a new byte may replace the old one only when it is
      // being consumed in the same cycle; otherwise the new byte is lost.
      if (byte_done) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-level reference model predicting output events
// from bit timing, compared every cycle, plus literal expectations per scenario.
module tb_uart_rx_ctrl;

  localparam int CLK_HZ = 50000000;
  localparam int OSR    = 16;
  localparam int NEVER  = 32'h7fffffff;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [2:0] baud_sel;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLK_HZ(CLK_HZ), .OSR(OSR)) dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_sel(baud_sel),
    .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected frame outcome: edge index where the stop bit is judged, and busy window.
  bit         ev_pending = 1'b0;
  int         ev_cyc = 0;
  bit         ev_ferr = 1'b0;
  logic [7:0] ev_byte = 8'h00;
  int         bsy_from = 0;
  int         bsy_to = 0;
  int         frame_k = 0;

  logic       m_valid, m_ferr, m_ovr;
  logic [7:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
    end else begin
      m_ferr <= 1'b0;
      m_ovr  <= 1'b0;
      if (ev_pending && (cyc + 1 == ev_cyc) && ev_ferr) m_ferr <= 1'b1;
      if (ev_pending && (cyc + 1 == ev_cyc) && !ev_ferr) begin
        if (!m_valid || ready) begin
          m_data  <= ev_byte;
          m_valid <= 1'b1;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cnt_valid = 0, cnt_ferr = 0, cnt_ovr = 0, rise_cyc = 0;
  logic prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int div_of(input int sel);
    int bauds[8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
    return CLK_HZ / (OSR * bauds[sel]);
  endfunction

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame start: rx falls after edge k, seen by the FSM two edges later,
  // START entered at k+3; stop bit is judged 152 ticks after that.
  task automatic send(input logic [7:0] b, input logic stopv, input logic [2:0] sel,
                      input bit toggle);
    int d;
    int k;
    d = div_of(int'(sel));
    baud_sel = sel;
    k = cyc;
    frame_k = k;
    ev_cyc = k + 3 + 152 * d;
    ev_ferr = !stopv;
    ev_byte = b;
    ev_pending = 1'b1;
    bsy_from = k + 3;
    bsy_to = stopv ? ev_cyc : NEVER;
    drive(1'b0, 16 * d);
    for (int i = 0; i < 8; i++) begin
      if (toggle && i == 3) baud_sel = 3'd7;
      drive(b[i], 16 * d);
    end
    drive(stopv, 16 * d);
    baud_sel = sel;
  endtask

  int cv, cf, co, k0;

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b0;
    baud_sel = 3'd0;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk($sformatf("cycle%0d{busy,valid,ferr,ovr,data}", cyc),
              32'({busy, valid, frame_err, overrun, data}),
              32'({(cyc >= bsy_from && cyc < bsy_to), m_valid, m_ferr, m_ovr, m_data}));
          if (valid && !prev_v) rise_cyc = cyc;
          if (valid) cnt_valid++;
          if (frame_err) cnt_ferr++;
          if (overrun) cnt_ovr++;
        end
        prev_v = valid;
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    rst = 1'b0;
    drive(1'b1, 5);

    // 0x55 at 115200 with immediate consumption
    ready = 1'b1;
    cv = cnt_valid; cf = cnt_ferr;
    send(8'h55, 1'b1, 3'd4, 1'b0);
    drive(1'b1, 10);
    chk("t55_data", 32'(data), 32'h55);
    chk("t55_valid_cycles", 32'(cnt_valid - cv), 32'd1);
    chk("t55_ferr", 32'(cnt_ferr - cf), 32'd0);
    chk("t55_latency", 32'(rise_cyc - frame_k), 32'd4107);
    chk("t55_busy", 32'(busy), 32'h0);

    // 0xA3 with a bad stop bit, line then held low
    cv = cnt_valid; cf = cnt_ferr;
    send(8'hA3, 1'b0, 3'd4, 1'b0);
    drive(1'b0, 2000);
    chk("brk_busy_low_line", 32'(busy), 32'h1);
    bsy_to = cyc + 3;
    drive(1'b1, 10);
    chk("brk_ferr_pulses", 32'(cnt_ferr - cf), 32'd1);
    chk("brk_no_valid", 32'(cnt_valid - cv), 32'd0);
    chk("brk_busy_after", 32'(busy), 32'h0);

    // Overrun: two bytes while the consumer stalls
    ready = 1'b0;
    send(8'h12, 1'b1, 3'd4, 1'b0);
    drive(1'b1, 5);
    chk("ovr_first_valid", 32'(valid), 32'h1);
    chk("ovr_first_data", 32'(data), 32'h12);
    co = cnt_ovr;
    send(8'h34, 1'b1, 3'd4, 1'b0);
    drive(1'b1, 5);
    chk("ovr_pulses", 32'(cnt_ovr - co), 32'd1);
    chk("ovr_data_held", 32'(data), 32'h12);
    ready = 1'b1;
    drive(1'b1, 1);
    ready = 1'b0;
    drive(1'b1, 2);
    chk("ovr_consumed_valid", 32'(valid), 32'h0);
    chk("ovr_consumed_data", 32'(data), 32'h12);

    // Glitches shorter than half a bit
    ev_pending = 1'b0;
    cv = cnt_valid; cf = cnt_ferr;
    baud_sel = 3'd7;
    k0 = cyc; bsy_from = k0 + 3; bsy_to = k0 + 3 + 8 * 3;
    drive(1'b0, 10);
    drive(1'b1, 60);
    baud_sel = 3'd4;
    k0 = cyc; bsy_from = k0 + 3; bsy_to = k0 + 3 + 8 * 27;
    drive(1'b0, 100);
    drive(1'b1, 300);
    chk("gl_no_valid", 32'(cnt_valid - cv), 32'd0);
    chk("gl_no_ferr", 32'(cnt_ferr - cf), 32'd0);
    chk("gl_busy", 32'(busy), 32'h0);

    // Reset in the middle of a 0xFF frame
    baud_sel = 3'd4;
    k0 = cyc; bsy_from = k0 + 3; bsy_to = NEVER;
    drive(1'b0, 432);
    drive(1'b1, 432 * 4);
    #3;
    bsy_to = cyc;
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_data", 32'(data), 32'h00);
    chk("mrst_valid", 32'(valid), 32'h0);
    chk("mrst_ferr", 32'(frame_err), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 5);
    send(8'h0F, 1'b1, 3'd4, 1'b0);
    drive(1'b1, 5);
    chk("post_rst_data", 32'(data), 32'h0F);
    chk("post_rst_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    drive(1'b1, 2);
    ready = 1'b0;

    // 9600 frame with baud_sel changed mid-frame
    send(8'hC6, 1'b1, 3'd0, 1'b1);
    drive(1'b1, 5);
    chk("slow_data", 32'(data), 32'hC6);
    chk("slow_valid", 32'(valid), 32'h1);
    chk("slow_latency", 32'(rise_cyc - frame_k), 32'd49403);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
